// File: rtl/audio_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module   : audio_adc_rx
//  Purpose  : WM8731 ADC serial receiver. This block deserialises the I2S
//             capture stream into {left,right} stereo words. The codec is
//             the bit and frame clock master.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_adc_rx #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    output logic [2*DATA_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int unsigned      c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L_SKIP  = 3'd1;
    localparam logic [2:0] S_L_SHIFT = 3'd2;
    localparam logic [2:0] S_L_WAIT  = 3'd3;
    localparam logic [2:0] S_R_SKIP  = 3'd4;
    localparam logic [2:0] S_R_SHIFT = 3'd5;
    localparam logic [2:0] S_R_WAIT  = 3'd6;

    logic [1:0]          r_bclk_sync;
    logic [1:0]          r_lr_sync;
    logic [1:0]          r_dat_sync;
    logic                r_bclk_d;
    logic                r_lr_d;

    logic [2:0]          r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_CNT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0]   r_left;
    logic                r_left_ok;

    logic                w_bclk_rise;
    logic                w_lr_fall;
    logic                w_lr_rise;
    logic                w_dat;
    logic                w_last_bit;
    logic [DATA_W-1:0]   w_word_next;

    // Two-stage synchronisers on all three codec pins. A third register on
    // the clock lines allows edge detection with the same delay as the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lr_d      <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], aud_bclk};
            r_lr_sync   <= {r_lr_sync[0], aud_adclrck};
            r_dat_sync  <= {r_dat_sync[0], aud_adcdat};
            r_bclk_d    <= r_bclk_sync[1];
            r_lr_d      <= r_lr_sync[1];
        end
    end

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_d;
    assign w_lr_fall   = r_lr_d & ~r_lr_sync[1];
    assign w_lr_rise   = ~r_lr_d & r_lr_sync[1];
    assign w_dat       = r_dat_sync[1];
    assign w_last_bit  = (r_bitcnt == c_LAST);
    assign w_word_next = {r_shift[DATA_W-2:0], w_dat};

    // Frame-alignment FSM and output registers. LRCK edges land half a bit
    // clock away from bclk_rise, so the two are never seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_left       <= '0;
            r_left_ok    <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (!en) begin
                // Partial frame is dropped silently; sample_out keeps its value.
                r_state   <= S_IDLE;
                r_shift   <= '0;
                r_bitcnt  <= '0;
                r_left_ok <= 1'b0;
                locked    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Only a left-channel start can align a frame.
                        if (w_lr_fall) begin
                            r_state   <= S_L_SKIP;
                            r_left_ok <= 1'b0;
                            locked    <= 1'b1;
                        end
                    end
                    S_L_SKIP: begin
                        if (w_lr_rise) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end else if (w_bclk_rise) begin
                            r_state  <= S_L_SHIFT;
                            r_bitcnt <= '0;
                            r_shift  <= '0;
                        end
                    end
                    S_L_SHIFT: begin
                        if (w_lr_rise) begin
                            // Short left word: realign on the right channel.
                            frame_err <= 1'b1;
                            r_state   <= S_R_SKIP;
                            r_left_ok <= 1'b0;
                        end else if (w_lr_fall) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end else if (w_bclk_rise) begin
                            r_shift  <= w_word_next;
                            r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                            if (w_last_bit) begin
                                r_left    <= w_word_next;
                                r_left_ok <= 1'b1;
                                r_state   <= S_L_WAIT;
                            end
                        end
                    end
                    S_L_WAIT: begin
                        if (w_lr_rise) begin
                            r_state <= S_R_SKIP;
                        end else if (w_lr_fall) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end
                    end
                    S_R_SKIP: begin
                        if (w_lr_fall) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end else if (w_bclk_rise) begin
                            r_state  <= S_R_SHIFT;
                            r_bitcnt <= '0;
                            r_shift  <= '0;
                        end
                    end
                    S_R_SHIFT: begin
                        if (w_lr_fall) begin
                            // Short right word: frame dropped, restart on left.
                            frame_err <= 1'b1;
                            r_state   <= S_L_SKIP;
                            r_left_ok <= 1'b0;
                        end else if (w_lr_rise) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end else if (w_bclk_rise) begin
                            r_shift  <= w_word_next;
                            r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                            if (w_last_bit) begin
                                // A frame is published only if its left word was whole.
                                if (r_left_ok) begin
                                    sample_out   <= {r_left, w_word_next};
                                    sample_valid <= 1'b1;
                                end
                                r_left_ok <= 1'b0;
                                r_state   <= S_R_WAIT;
                            end
                        end
                    end
                    S_R_WAIT: begin
                        if (w_lr_fall) begin
                            r_state   <= S_L_SKIP;
                            r_left_ok <= 1'b0;
                        end else if (w_lr_rise) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_adc_rx
//  Purpose  : Self-checking bench for audio_adc_rx. It drives an I2S codec
//             BFM with 32 slots per channel and bclk = clk/16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_adc_rx;

    localparam int DATA_W = 16;

    logic                clk;
    logic                reset;
    logic                en;
    logic                aud_bclk;
    logic                aud_adclrck;
    logic                aud_adcdat;
    logic [2*DATA_W-1:0] sample_out;
    logic                sample_valid;
    logic                frame_err;
    logic                locked;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    audio_adc_rx #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: collects published words and counts error pulses.
    always @(posedge clk) begin
        #1;
        if (sample_valid) got_q.push_back(sample_out);
        if (frame_err) err_cnt++;
        if (sample_valid && frame_err) both_cnt++;
    end

    // One bit slot: LRCK/data change with the BCLK falling edge, held for a full period.
    task automatic bfm_slot(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        repeat (8) @(negedge clk);
        aud_bclk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Slot 0 is the I2S delay slot, slots 1..16 carry the word MSB first, the rest is pad.
    task automatic send_chan(input logic lr, input logic [15:0] word, input int nslots);
        logic d;
        for (int i = 0; i < nslots; i++) begin
            if (i >= 1 && i <= 16) d = word[16 - i];
            else d = 1'($urandom % 2);
            bfm_slot(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_chan(1'b0, l, 32);
        send_chan(1'b1, r, 32);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (sample_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_sample_out got %h want %h", sample_out, 32'h0);
        end
        n_tests++;
        if (sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", sample_valid);
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err);
        end
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_locked got %b want 0", locked);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        int e0;
        en = 1'b1;
        send_chan(1'b1, 16'h0000, 32);
        got_q.delete();
        e0 = err_cnt;
        send_frame(16'hA5C3, 16'h1234);
        n_tests++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL single_count got %0d want 1", got_q.size());
        end
        n_tests++;
        if (got_q.size() < 1 || got_q[0] !== 32'hA5C31234) begin
            n_fail++; $display("FAIL single_word got %h want %h", sample_out, 32'hA5C31234);
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL single_locked got %b want 1", locked);
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL single_err got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_mid_start;
        int e0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        e0 = err_cnt;
        send_chan(1'b1, 16'hFFFF, 10);
        n_tests++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL mid_early_valid got %0d want 0", got_q.size());
        end
        send_chan(1'b1, 16'hFFFF, 22);
        exp_q.delete();
        exp_q.push_back(32'h80007FFF);
        exp_q.push_back(32'h0001FFFF);
        send_frame(16'h8000, 16'h7FFF);
        send_frame(16'h0001, 16'hFFFF);
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL mid_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL mid_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL mid_err got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_short_word;
        int e0;
        got_q.delete();
        e0 = err_cnt;
        send_chan(1'b0, 16'hFFFF, 11);
        send_chan(1'b1, 16'($urandom), 32);
        n_tests++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL short_err got %0d want 1", err_cnt - e0);
        end
        n_tests++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL short_bad_valid got %0d want 0", got_q.size());
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL short_locked got %b want 1", locked);
        end
        send_frame(16'h0F0F, 16'hF0F0);
        n_tests++;
        if (got_q.size() !== 1 || got_q[0] !== 32'h0F0FF0F0) begin
            n_fail++; $display("FAIL short_recover got %h (n=%0d) want %h", sample_out, got_q.size(), 32'h0F0FF0F0);
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        send_chan(1'b0, 16'h1111, 32);
        send_chan(1'b1, 16'h2222, 10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (sample_out !== 32'h0 || sample_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs got %h/%b/%b want 0/0/0", sample_out, sample_valid, frame_err);
        end
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_locked got %b want 0", locked);
        end
        send_chan(1'b1, 16'h2222, 22);
        n_tests++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_early_valid got %0d want 0", got_q.size());
        end
        send_frame(16'h3333, 16'h4444);
        n_tests++;
        if (got_q.size() !== 1 || got_q[0] !== 32'h33334444) begin
            n_fail++; $display("FAIL rstmid_next got %h (n=%0d) want %h", sample_out, got_q.size(), 32'h33334444);
        end
    endtask

    task automatic test_back_to_back;
        int e0;
        int b0;
        logic [15:0] l;
        logic [15:0] r;
        got_q.delete();
        exp_q.delete();
        e0 = err_cnt;
        b0 = both_cnt;
        for (int f = 0; f < 64; f++) begin
            if (f == 0)      begin l = 16'h8000; r = 16'h7FFF; end
            else if (f == 1) begin l = 16'h7FFF; r = 16'h8000; end
            else             begin l = 16'($urandom); r = 16'($urandom); end
            exp_q.push_back({l, r});
            send_frame(l, r);
        end
        last_exp = exp_q[63];
        n_tests++;
        if (got_q.size() !== 64) begin
            n_fail++; $display("FAIL b2b_count got %0d want 64", got_q.size());
        end
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (err_cnt - e0 !== 0 || both_cnt - b0 !== 0) begin
            n_fail++; $display("FAIL b2b_err got %0d/%0d want 0/0", err_cnt - e0, both_cnt - b0);
        end
    endtask

    task automatic test_enable;
        int e0;
        got_q.delete();
        e0 = err_cnt;
        send_chan(1'b0, 16'hAAAA, 10);
        en = 1'b0;
        send_chan(1'b0, 16'hAAAA, 6);
        repeat (4) @(negedge clk);
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL en_locked got %b want 0", locked);
        end
        n_tests++;
        if (sample_out !== last_exp) begin
            n_fail++; $display("FAIL en_hold got %h want %h", sample_out, last_exp);
        end
        en = 1'b1;
        send_chan(1'b0, 16'hAAAA, 16);
        send_chan(1'b1, 16'h5555, 32);
        n_tests++;
        if (got_q.size() !== 0 || err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL en_partial got valid=%0d err=%0d want 0/0", got_q.size(), err_cnt - e0);
        end
        send_frame(16'hC001, 16'hBEEF);
        n_tests++;
        if (got_q.size() !== 1 || got_q[0] !== 32'hC001BEEF) begin
            n_fail++; $display("FAIL en_resume got %h (n=%0d) want %h", sample_out, got_q.size(), 32'hC001BEEF);
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL en_relock got %b want 1", locked);
        end
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b1;
        aud_adcdat  = 1'b0;
        last_exp    = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_mid_start();
        test_short_word();
        test_reset_mid();
        test_back_to_back();
        test_enable();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++; $display("FAIL valid_err_overlap got %0d want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
